// File: rtl/ebpc_out_arbiter.sv
// Round-robin packet arbiter merging the BPC and ZNZ encoder streams onto one
// registered output port; each output word carries a source tag and a burst-break flag.
module ebpc_out_arbiter #(
  parameter  int DATA_W    = 8,
  parameter  int BURST_MAX = 16,
  localparam int CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] bpc_data_i,
  input  logic              bpc_last_i,
  input  logic              bpc_vld_i,
  output logic              bpc_rdy_o,
  input  logic [DATA_W-1:0] znz_data_i,
  input  logic              znz_last_i,
  input  logic              znz_vld_i,
  output logic              znz_rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              src_o,
  output logic              brk_o,
  output logic              vld_o,
  input  logic              rdy_i
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_BPC,
    GNT_ZNZ
  } state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               out_free;
  logic               acc;
  logic               acc_last;
  logic [DATA_W-1:0]  acc_data;
  logic               at_limit;
  logic               grant_end;

  // Readies are masked during reset so nothing is accepted on the reset edge.
  assign out_free  = ~vld_o | rdy_i;
  assign bpc_rdy_o = ~rst_i & (state_q == GNT_BPC) & out_free;
  assign znz_rdy_o = ~rst_i & (state_q == GNT_ZNZ) & out_free;
  assign acc       = (bpc_rdy_o & bpc_vld_i) | (znz_rdy_o & znz_vld_i);
  assign acc_data  = (state_q == GNT_ZNZ) ? znz_data_i : bpc_data_i;
  assign acc_last  = (state_q == GNT_ZNZ) ? znz_last_i : bpc_last_i;
  assign at_limit  = (cnt_q == CNT_W'(BURST_MAX - 1));
  assign grant_end = acc & (acc_last | at_limit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // A finished grant always hands priority to the other input; re-granting the
  // same input therefore has to go through IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bpc_vld_i && znz_vld_i) begin
          state_d = ptr_q ? GNT_ZNZ : GNT_BPC;
        end else if (bpc_vld_i) begin
          state_d = GNT_BPC;
        end else if (znz_vld_i) begin
          state_d = GNT_ZNZ;
        end
      end
      GNT_BPC: begin
        if (grant_end) begin
          ptr_d   = 1'b1;
          cnt_d   = '0;
          state_d = znz_vld_i ? GNT_ZNZ : IDLE;
        end else if (acc) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GNT_ZNZ: begin
        if (grant_end) begin
          ptr_d   = 1'b0;
          cnt_d   = '0;
          state_d = bpc_vld_i ? GNT_BPC : IDLE;
        end else if (acc) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= '0;
      last_o <= 1'b0;
      src_o  <= 1'b0;
      brk_o  <= 1'b0;
      vld_o  <= 1'b0;
    end else if (acc) begin
      data_o <= acc_data;
      last_o <= acc_last;
      src_o  <= (state_q == GNT_ZNZ);
      brk_o  <= at_limit & ~acc_last;
      vld_o  <= 1'b1;
    end else if (rdy_i) begin
      vld_o  <= 1'b0;
    end
  end

endmodule

// File: doc/ebpc_out_arbiter.md
Name: ebpc_out_arbiter

Overview:
- Shares one output stream between the two encoder output streams: the BPC stream (input A) and the zero/non-zero (ZNZ) stream (input B).
- Sits between the encoder buffers and the single downstream packer port.
- Arbitrates at packet granularity. A grant is held until the granted input delivers a word with last set, or until BURST_MAX words have been accepted.
- Grants rotate round-robin, and every output word is tagged with its source.

Parameters:
- DATA_W, 8, width of data on both inputs and the output.
- BURST_MAX, 16, maximum words accepted per grant (must be ≥1).
- CNT_W, $clog2(BURST_MAX+1), width of the burst counter (derived; do not override).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- bpc_data_i  in  DATA_W  BPC stream data.
- bpc_last_i  in  1  last word of BPC packet.
- bpc_vld_i  in  1  BPC word valid.
- bpc_rdy_o  out  1  BPC word accepted when high together with bpc_vld_i.
- znz_data_i  in  DATA_W  ZNZ stream data.
- znz_last_i  in  1  last word of ZNZ packet.
- znz_vld_i  in  1  ZNZ word valid.
- znz_rdy_o  out  1  ZNZ word accepted when high together with znz_vld_i.
- data_o  out  DATA_W  output data (registered).
- last_o  out  1  copy of the accepted word's last flag.
- src_o  out  1  source tag: 0 = BPC, 1 = ZNZ.
- brk_o  out  1  word ended a grant on BURST_MAX without last.
- vld_o  out  1  output valid.
- rdy_i  in  1  downstream ready.

Behaviour:
- Reset: synchronous and active-high, taking effect on the clock edge. The clock is clk_i; the reset is rst_i.
  - Reset sets state IDLE, priority pointer to BPC, counter 0.
  - All output register fields reset to 0, so vld_o=0, data_o=0, last_o=0, src_o=0, brk_o=0.
  - Asserting reset mid-transfer discards the held output word and any grant. No partial recovery.
- Output register: single entry.
  - out_free = ~vld_o | rdy_i.
  - An accepted input word is loaded into data_o/last_o/src_o/brk_o and vld_o=1 on the next edge.
  - If vld_o && rdy_i and nothing is accepted, vld_o clears.
  - Input-to-output latency is exactly 1 cycle. Throughput is 1 word/cycle while a grant is held and rdy_i stays high.
  - data_o/last_o/src_o/brk_o are held stable while vld_o && ~rdy_i.
- Ready rules: bpc_rdy_o = (state==GNT_BPC) & out_free. znz_rdy_o = (state==GNT_ZNZ) & out_free. The two are never high together, and neither is high in IDLE.
- States:
  - IDLE: no acceptance.
    - If exactly one vld_i is high, go to that grant.
    - If both are high, go to the grant named by the priority pointer.
    - If neither is high, stay.
    - cnt ← 0.
  - GNT_BPC / GNT_ZNZ: on each accept, cnt ← cnt+1. The grant ends on an accept with last_i=1, or with cnt==BURST_MAX-1.
    - On grant end, the priority pointer is set to the other input. The next state is the other grant if its vld_i is high in that cycle, else IDLE. cnt ← 0.
    - With no accept, the state holds. This includes the granted input deasserting vld_i mid-packet: the grant is kept, no timeout.
- brk_o: brk_o=1 on the word that ends a grant by count with last_i=0. Otherwise brk_o=0. A word with last_i=1 on count BURST_MAX has brk_o=0.
- Arbitration latency:
  - First grant from IDLE costs one bubble cycle.
  - Back-to-back handover between inputs costs no bubble.
  - A re-grant to the same input always passes through IDLE, even if the other input is idle.
- BURST_MAX=1: every word ends its grant, so each word alternates through IDLE or handover.
- Invariant: words of one input appear at the output in input order, with no duplication or loss.

Test Plan:
- Reset, then BPC sends a 3-word packet {0x11,0x22,0x33(last)} with rdy_i=1 → one IDLE cycle, then bpc_rdy_o high 3 cycles. Output 0x11,0x22,0x33 on consecutive cycles with src_o=0, last_o only on 0x33; state returns to IDLE.
- Both inputs valid from reset, each with 2-word packets → BPC granted first (pointer reset value). Output is B0,B1(last),Z0,Z1(last) with no bubble between B1 and Z0. Pointer then points to BPC.
- BURST_MAX=16, BPC sends a 20-word packet while ZNZ holds a 1-word packet → 16 BPC words, the 16th with brk_o=1, last_o=0. Then ZNZ word (src_o=1, last_o=1). Then the remaining 4 BPC words, the last with last_o=1.
- Backpressure: rdy_i low for 5 cycles during a BPC packet → vld_o stays 1, data_o stable. bpc_rdy_o low for those 5 cycles; no word is lost or duplicated after rdy_i rises.
- Granted input drops vld_i for 3 cycles mid-packet while ZNZ is valid → the grant stays on BPC and znz_rdy_o stays 0. BPC resumes and completes, then ZNZ is served.
- rst_i asserted for one cycle while vld_o=1 and in GNT_ZNZ → next cycle vld_o=0, state IDLE, pointer=BPC. Both rdy outputs are 0 during the reset cycle.
